// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_ctrl
//  Purpose  : Arbitrates fetch and load/store traffic onto a single-outstanding
//             memory bus, aligns byte lanes and stalls exec on data accesses.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // fetch port
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_valid_out,
    output logic [31:0] if_instr_out,
    // exec load/store port
    input  logic        dmem_read_en_in,
    input  logic        dmem_write_en_in,
    input  logic [31:0] dmem_addr_in,
    input  logic [31:0] dmem_wdata_in,
    input  logic [3:0]  dmem_byte_num_in,
    output logic        dmem_valid_out,
    output logic [31:0] dmem_rdata_out,
    output logic        ctrl_stall_out,
    output logic        ctrl_err_out,
    // memory bus
    output logic        bus_req_out,
    output logic        bus_we_out,
    output logic [31:0] bus_addr_out,
    output logic [31:0] bus_wdata_out,
    output logic [3:0]  bus_wstrb_out,
    input  logic        bus_gnt_in,
    input  logic        bus_rvalid_in,
    input  logic [31:0] bus_rdata_in
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic        r_owner_data;
    logic        r_we;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_strb;
    logic [31:0] r_word;
    logic [15:0] r_count;

    logic        w_data_req;
    logic        w_store_bad;
    logic        w_timeout;
    logic        w_done;
    logic        w_load_ok;
    logic [4:0]  w_in_shift;
    logic [4:0]  w_out_shift;

    assign w_data_req  = dmem_read_en_in | dmem_write_en_in;
    assign w_in_shift  = {dmem_addr_in[1:0], 3'b000};
    assign w_out_shift = {r_addr[1:0], 3'b000};
    assign w_timeout   = (r_count == C_TIMEOUT_LAST);

    // Stores that would not fit their natural alignment never reach the bus.
    always_comb begin
        w_store_bad = 1'b0;
        if (dmem_write_en_in) begin
            case (dmem_byte_num_in)
                4'b0000: w_store_bad = 1'b1;
                4'b0011: w_store_bad = dmem_addr_in[0];
                4'b1111: w_store_bad = |dmem_addr_in[1:0];
                default: w_store_bad = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner_data <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_strb       <= '0;
            r_word       <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_err   <= 1'b0;
                    r_word  <= '0;
                    r_count <= '0;
                    if (w_data_req) begin
                        r_owner_data <= 1'b1;
                        r_we         <= dmem_write_en_in;
                        r_addr       <= dmem_addr_in;
                        r_wdata      <= dmem_write_en_in ? (dmem_wdata_in << w_in_shift) : '0;
                        r_strb       <= dmem_write_en_in ? (dmem_byte_num_in << dmem_addr_in[1:0]) : '0;
                        if (w_store_bad) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_REQ;
                        end
                    end else if (if_req_in) begin
                        r_owner_data <= 1'b0;
                        r_we         <= 1'b0;
                        r_addr       <= if_addr_in;
                        r_wdata      <= '0;
                        r_strb       <= '0;
                        r_state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_count <= r_count + 16'd1;
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (bus_gnt_in) begin
                        r_state <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    r_count <= r_count + 16'd1;
                    // A response on the final allowed cycle still counts as success.
                    if (bus_rvalid_in) begin
                        r_word  <= bus_rdata_in;
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_done         = (r_state == ST_DONE);
    assign bus_req_out    = (r_state == ST_REQ);
    assign bus_we_out     = bus_req_out & r_we;
    assign bus_addr_out   = bus_req_out ? {r_addr[31:2], 2'b00} : '0;
    assign bus_wdata_out  = bus_req_out ? r_wdata : '0;
    assign bus_wstrb_out  = bus_req_out ? r_strb : '0;

    assign dmem_valid_out = w_done & r_owner_data;
    assign if_valid_out   = w_done & ~r_owner_data;
    assign ctrl_err_out   = w_done & r_err;

    assign w_load_ok      = dmem_valid_out & ~r_err & ~r_we;
    assign dmem_rdata_out = w_load_ok ? (r_word >> w_out_shift) : '0;
    assign if_instr_out   = (if_valid_out & ~r_err) ? r_word : '0;

    // Stall drops only in the completion cycle of a data access.
    assign ctrl_stall_out = w_data_req & ~dmem_valid_out;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_ctrl
//  Purpose  : Self-checking bench for mem_bus_ctrl with a transaction model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req_in, if_valid_out;
    logic [31:0] if_addr_in, if_instr_out;
    logic        dmem_read_en_in, dmem_write_en_in, dmem_valid_out;
    logic [31:0] dmem_addr_in, dmem_wdata_in, dmem_rdata_out;
    logic [3:0]  dmem_byte_num_in;
    logic        ctrl_stall_out, ctrl_err_out;
    logic        bus_req_out, bus_we_out, bus_gnt_in, bus_rvalid_in;
    logic [31:0] bus_addr_out, bus_wdata_out, bus_rdata_in;
    logic [3:0]  bus_wstrb_out;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .if_valid_out(if_valid_out), .if_instr_out(if_instr_out),
        .dmem_read_en_in(dmem_read_en_in), .dmem_write_en_in(dmem_write_en_in),
        .dmem_addr_in(dmem_addr_in), .dmem_wdata_in(dmem_wdata_in),
        .dmem_byte_num_in(dmem_byte_num_in), .dmem_valid_out(dmem_valid_out),
        .dmem_rdata_out(dmem_rdata_out), .ctrl_stall_out(ctrl_stall_out),
        .ctrl_err_out(ctrl_err_out), .bus_req_out(bus_req_out),
        .bus_we_out(bus_we_out), .bus_addr_out(bus_addr_out),
        .bus_wdata_out(bus_wdata_out), .bus_wstrb_out(bus_wstrb_out),
        .bus_gnt_in(bus_gnt_in), .bus_rvalid_in(bus_rvalid_in),
        .bus_rdata_in(bus_rdata_in)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    bit          m_busy, m_data, m_we, m_granted, m_finish, m_err;
    logic [31:0] m_addr, m_wdata, m_word;
    logic [3:0]  m_bn;
    int          m_age;

    function automatic bit store_misfit(input logic [31:0] a, input logic [3:0] bn);
        int size;
        size = $countones(bn);
        if (size == 0) return 1'b1;
        return (int'(a[1:0]) % size) != 0;
    endfunction

    task automatic m_clear();
        m_busy = 0; m_data = 0; m_we = 0; m_granted = 0; m_finish = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_word = '0; m_bn = '0; m_age = 0;
    endtask

    task automatic m_step();
        if (m_finish) begin
            m_busy = 0; m_finish = 0; m_err = 0;
        end else if (!m_busy) begin
            if (dmem_read_en_in || dmem_write_en_in) begin
                m_busy = 1; m_data = 1; m_we = dmem_write_en_in; m_addr = dmem_addr_in;
                m_wdata = dmem_wdata_in; m_bn = dmem_byte_num_in;
                m_granted = 0; m_age = 0; m_word = '0;
                if (m_we && store_misfit(m_addr, m_bn)) begin
                    m_finish = 1; m_err = 1;
                end
            end else if (if_req_in) begin
                m_busy = 1; m_data = 0; m_we = 0; m_addr = if_addr_in;
                m_wdata = '0; m_bn = '0; m_granted = 0; m_age = 0; m_word = '0;
            end
        end else begin
            m_age++;
            if (!m_granted) begin
                if (bus_gnt_in) m_granted = 1;
            end else if (bus_rvalid_in) begin
                m_word = bus_rdata_in; m_finish = 1;
            end
            if (!m_finish && m_age >= TO) begin
                m_finish = 1; m_err = 1;
            end
        end
    endtask

    function automatic bit e_req();
        return m_busy && !m_granted && !m_finish;
    endfunction
    function automatic bit e_wr_phase();
        return e_req() && m_we;
    endfunction
    function automatic logic [31:0] e_wdata();
        return e_wr_phase() ? (m_wdata << (8 * int'(m_addr[1:0]))) : 32'h0;
    endfunction
    function automatic logic [3:0] e_wstrb();
        logic [3:0] s;
        s = m_bn << m_addr[1:0];
        return e_wr_phase() ? s : 4'h0;
    endfunction
    function automatic logic [31:0] e_dmem_rdata();
        if (m_finish && m_data && !m_err && !m_we) return m_word >> (8 * int'(m_addr[1:0]));
        return 32'h0;
    endfunction
    function automatic logic [31:0] e_instr();
        return (m_finish && !m_data && !m_err) ? m_word : 32'h0;
    endfunction

    initial begin
        m_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_clear();
            else m_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("bus_req", bus_req_out, e_req());
            chk("bus_we", bus_we_out, e_wr_phase());
            chk("bus_addr", bus_addr_out, e_req() ? (m_addr & 32'hFFFF_FFFC) : 32'h0);
            chk("bus_wdata", bus_wdata_out, e_wdata());
            chk("bus_wstrb", bus_wstrb_out, e_wstrb());
            chk("dmem_valid", dmem_valid_out, m_finish && m_data);
            chk("dmem_rdata", dmem_rdata_out, e_dmem_rdata());
            chk("if_valid", if_valid_out, m_finish && !m_data);
            chk("if_instr", if_instr_out, e_instr());
            chk("ctrl_err", ctrl_err_out, m_finish && m_err);
            chk("ctrl_stall", ctrl_stall_out,
                (dmem_read_en_in || dmem_write_en_in) && !(m_finish && m_data));
        end
    end

    // ---------------- bus responder ----------------
    bit          zero_wait = 1, no_rsp = 0, fix_en = 0;
    logic [31:0] fix_rdata = '0;
    bit          pend = 0;
    int          gwait = 0, rwait = 0;

    initial begin
        bus_gnt_in = 0; bus_rvalid_in = 0; bus_rdata_in = '0;
        forever begin
            @(posedge clk); #1;
            bus_gnt_in = 0; bus_rvalid_in = 0; bus_rdata_in = $urandom;
            if (!rst_n) begin
                pend = 0; gwait = 0;
            end else if (pend) begin
                if (rwait == 0) begin
                    bus_rvalid_in = 1;
                    if (fix_en) bus_rdata_in = fix_rdata;
                    pend = 0;
                end else rwait--;
            end else if (bus_req_out) begin
                if (gwait == 0) begin
                    bus_gnt_in = 1;
                    pend  = !no_rsp;
                    rwait = zero_wait ? 0 : $urandom_range(0, 2);
                    gwait = zero_wait ? 0 : $urandom_range(0, 2);
                end else gwait--;
            end
        end
    end

    // ---------------- fetch requester ----------------
    bit fetch_en = 0, fetch_go = 0, done_f;
    int fwait = 0;

    initial begin
        if_req_in = 0; if_addr_in = '0;
        forever begin
            @(negedge clk);
            done_f = if_valid_out;
            if (fetch_en && if_req_in && !if_valid_out) fwait++;
            else fwait = 0;
            if (fwait > 60) begin
                chk("fetch_wait", if_valid_out, 1);
                fwait = 0;
            end
            @(posedge clk); #1;
            if (fetch_en && (done_f || !if_req_in)) begin
                if (fetch_go && $urandom_range(0, 2) != 0) begin
                    if_req_in  = 1;
                    if_addr_in = $urandom & 32'hFFFF_FFFC;
                end else if_req_in = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_data(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] bn);
        dmem_read_en_in = rd; dmem_write_en_in = wr; dmem_addr_in = a;
        dmem_wdata_in = wd; dmem_byte_num_in = bn;
    endtask

    task automatic run_op(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] bn);
        @(posedge clk); #1;
        set_data(!wr, wr, a, wd, bn);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (dmem_valid_out) break;
        end
        chk("dmem_valid_wait", dmem_valid_out, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "stopping");
    end

    initial begin
        int ivc, ivcyc, freq_cyc, dvcyc;
        set_data(0, 0, 0, 0, 0);
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", bus_req_out, 0);
        chk("rst_bus_addr", bus_addr_out, 0);
        chk("rst_dmem_valid", dmem_valid_out, 0);
        chk("rst_if_valid", if_valid_out, 0);
        chk("rst_stall", ctrl_stall_out, 0);
        @(posedge clk); #1 rst_n = 1;

        // LW 0x100, zero-wait bus
        fix_en = 1; fix_rdata = 32'hDEADBEEF;
        @(posedge clk); #1; set_data(1, 0, 32'h100, 0, 4'hF);
        @(negedge clk); chk("lw_c0_stall", ctrl_stall_out, 1); chk("lw_c0_req", bus_req_out, 0);
        @(negedge clk); chk("lw_c1_req", bus_req_out, 1); chk("lw_c1_addr", bus_addr_out, 32'h100);
        chk("lw_c1_we", bus_we_out, 0); chk("lw_c1_stall", ctrl_stall_out, 1);
        @(negedge clk); chk("lw_c2_stall", ctrl_stall_out, 1); chk("lw_c2_valid", dmem_valid_out, 0);
        @(negedge clk); chk("lw_c3_valid", dmem_valid_out, 1);
        chk("lw_c3_rdata", dmem_rdata_out, 32'hDEADBEEF); chk("lw_c3_stall", ctrl_stall_out, 0);
        chk("model_lw_rdata", e_dmem_rdata(), 32'hDEADBEEF);
        @(posedge clk); #1; set_data(0, 0, 0, 0, 0);
        @(negedge clk); chk("lw_c4_valid", dmem_valid_out, 0);

        // SB 0x203
        @(posedge clk); #1; set_data(0, 1, 32'h203, 32'hAB, 4'b0001);
        @(negedge clk);
        @(negedge clk); chk("sb_addr", bus_addr_out, 32'h200); chk("sb_strb", bus_wstrb_out, 4'b1000);
        chk("sb_wdata", bus_wdata_out, 32'hAB00_0000); chk("sb_we", bus_we_out, 1);
        chk("model_sb_strb", e_wstrb(), 4'b1000);
        @(negedge clk);
        @(negedge clk); chk("sb_valid", dmem_valid_out, 1); chk("sb_err", ctrl_err_out, 0);
        chk("sb_rdata", dmem_rdata_out, 0);
        @(posedge clk); #1; set_data(0, 0, 0, 0, 0);

        // LB 0x102
        fix_rdata = 32'h1122_3344;
        @(posedge clk); #1; set_data(1, 0, 32'h102, 0, 4'b0001);
        repeat (4) @(negedge clk);
        chk("lb_valid", dmem_valid_out, 1); chk("lb_rdata", dmem_rdata_out, 32'h0000_1122);
        chk("model_lb_rdata", e_dmem_rdata(), 32'h0000_1122);
        @(posedge clk); #1; set_data(0, 0, 0, 0, 0);

        // simultaneous fetch 0x0 and LW 0x40
        fix_rdata = 32'h0000_0013;
        @(posedge clk); #1; set_data(1, 0, 32'h40, 0, 4'hF); if_req_in = 1; if_addr_in = 32'h0;
        ivc = 0; ivcyc = -1; freq_cyc = -1; dvcyc = -1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 1) chk("arb_first_addr", bus_addr_out, 32'h40);
            if (bus_req_out && bus_addr_out == 32'h0 && freq_cyc < 0) freq_cyc = i;
            if (dmem_valid_out) dvcyc = i;
            if (if_valid_out) begin
                ivc++; ivcyc = i;
                chk("arb_instr", if_instr_out, 32'h13);
                @(posedge clk); #1; if_req_in = 0;
            end else if (i == 3) begin
                @(posedge clk); #1; set_data(0, 0, 0, 0, 0);
            end
        end
        chk("arb_data_done_cyc", dvcyc, 3);
        chk("arb_fetch_req_cyc", freq_cyc, 5);
        chk("arb_if_valid_cyc", ivcyc, 7);
        chk("arb_if_valid_count", ivc, 1);

        // SW 0x302 misaligned
        @(posedge clk); #1; set_data(0, 1, 32'h302, 32'h1234_5678, 4'hF);
        @(negedge clk); chk("sw_c0_req", bus_req_out, 0);
        @(negedge clk); chk("sw_c1_req", bus_req_out, 0); chk("sw_c1_err", ctrl_err_out, 1);
        chk("sw_c1_valid", dmem_valid_out, 1); chk("sw_c1_rdata", dmem_rdata_out, 0);
        @(posedge clk); #1; set_data(0, 0, 0, 0, 0);
        @(negedge clk); chk("sw_c2_err", ctrl_err_out, 0);

        // randomized traffic
        fix_en = 0; zero_wait = 0; fetch_en = 1; fetch_go = 1;
        for (int k = 0; k < 250; k++) begin
            int kind, gap;
            logic [3:0]  bn;
            logic [31:0] a;
            bit wr;
            kind = $urandom_range(0, 5);
            wr   = (kind >= 3);
            a    = $urandom;
            bn   = (kind % 3 == 0) ? 4'b0001 : ((kind % 3 == 1) ? 4'b0011 : 4'b1111);
            if ($urandom_range(0, 3) != 0) begin
                if (bn == 4'b0011) a[0] = 1'b0;
                if (bn == 4'b1111) a[1:0] = 2'b00;
            end
            if (wr && $urandom_range(0, 15) == 0) bn = 4'b0000;
            run_op(wr, a, $urandom, bn);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                @(posedge clk); #1; set_data(0, 0, 0, 0, 0);
                repeat (gap - 1) @(posedge clk);
            end
        end
        @(posedge clk); #1; set_data(0, 0, 0, 0, 0);
        fetch_go = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!if_req_in) break;
        end
        chk("fetch_quiesce", if_req_in, 0);
        fetch_en = 0;
        repeat (2) @(posedge clk);

        // timeout: grant given, response never
        zero_wait = 1; no_rsp = 1;
        @(posedge clk); #1; set_data(1, 0, 32'h500, 0, 4'hF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 1) chk("to_c1_req", bus_req_out, 1);
            if (i == 8) begin
                chk("to_c8_valid", dmem_valid_out, 0); chk("to_c8_err", ctrl_err_out, 0);
            end
            if (i == 9) begin
                chk("to_c9_valid", dmem_valid_out, 1); chk("to_c9_err", ctrl_err_out, 1);
                chk("to_c9_rdata", dmem_rdata_out, 0);
            end
        end
        @(posedge clk); #1; set_data(0, 0, 0, 0, 0);

        // reset in the middle of a response wait
        @(posedge clk); #1; set_data(1, 0, 32'h600, 0, 4'hF);
        repeat (3) @(negedge clk);
        chk("rr_in_rsp_req", bus_req_out, 0);
        #1; set_data(0, 0, 0, 0, 0); rst_n = 0;
        #1;
        chk("rr_bus_req", bus_req_out, 0); chk("rr_bus_we", bus_we_out, 0);
        chk("rr_bus_addr", bus_addr_out, 0); chk("rr_bus_wdata", bus_wdata_out, 0);
        chk("rr_bus_wstrb", bus_wstrb_out, 0); chk("rr_dmem_valid", dmem_valid_out, 0);
        chk("rr_dmem_rdata", dmem_rdata_out, 0); chk("rr_if_valid", if_valid_out, 0);
        chk("rr_if_instr", if_instr_out, 0); chk("rr_err", ctrl_err_out, 0);
        chk("rr_stall", ctrl_stall_out, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1; no_rsp = 0;
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Sequences all memory traffic of the core onto one shared single-outstanding memory bus: it arbitrates between the instruction-fetch port and the exec-stage load/store port, aligns byte lanes, stalls the pipeline while a data access is in flight, and returns a one-cycle `exec_mem_valid_in` pulse with load data to exec. It sits between the pipeline (fetch and exec) and the memory bus and contains a 4-state FSM plus a timeout counter.

## Interface
- TIMEOUT_CYCLES, 255: max cycles from bus_req issue to bus_rvalid before the access is aborted with an error (1..65535).
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req_in  in  1  fetch request, held until if_valid_out.
- if_addr_in  in  32  fetch address, word aligned.
- if_valid_out  out  1  one-cycle pulse: if_instr_out valid.
- if_instr_out  out  32  fetched word.
- dmem_read_en_in  in  1  from exec read_mem_en.
- dmem_write_en_in  in  1  from exec write_mem_en.
- dmem_addr_in  in  32  from exec mem_addr (byte address).
- dmem_wdata_in  in  32  from exec mem_data (low-aligned).
- dmem_byte_num_in  in  4  from exec byte_num: 0001/0011/1111.
- dmem_valid_out  out  1  one-cycle completion pulse, drives exec mem_valid.
- dmem_rdata_out  out  32  load word, shifted right by 8*addr[1:0].
- ctrl_stall_out  out  1  freezes pipeline registers while data access pending.
- ctrl_err_out  out  1  one-cycle pulse: misaligned store, zero byte_num store, or timeout.
- bus_req_out  out  1  request, held until bus_gnt_in.
- bus_we_out  out  1  1 = write.
- bus_addr_out  out  32  word address ({addr[31:2],2'b00}).
- bus_wdata_out  out  32  lane-shifted write data.
- bus_wstrb_out  out  4  byte strobes.
- bus_gnt_in  in  1  request accepted this cycle.
- bus_rvalid_in  in  1  response (reads and writes), one cycle.
- bus_rdata_in  in  32  read data, valid with bus_rvalid_in.

## Operation
- States: IDLE, REQ, RSP, DONE; registered owner bit (DATA/FETCH) and captured addr/wdata/strb/we.
- IDLE: data request (read_en|write_en) wins over if_req_in. Capture request, go REQ. Store with byte_num=0, SH with addr[0]=1, or SW with addr[1:0]!=0: no bus access, go DONE with error flag.
- REQ: bus_req_out=1; on bus_gnt_in go RSP (same-cycle rvalid not allowed by bus).
- RSP: on bus_rvalid_in latch bus_rdata_in, go DONE.
- DONE (one cycle): owner DATA -> dmem_valid_out=1, dmem_rdata_out = latched word >> 8*addr[1:0] (stores: 0); owner FETCH -> if_valid_out=1, if_instr_out = latched word. Error flag -> ctrl_err_out=1, data 0. Requests ignored in DONE; return to IDLE.
- Write lanes: bus_wstrb_out = byte_num << addr[1:0]; bus_wdata_out = wdata << 8*addr[1:0].
- Timeout: counter clears on entering REQ, increments each REQ/RSP cycle; reaching TIMEOUT_CYCLES -> DONE with error, bus_req dropped.
- ctrl_stall_out = (read_en|write_en) & !(state==DONE & owner==DATA). Combinational; no preemption: data request arriving during fetch stays stalled until fetch DONE, then wins.
- Fetch request during data access waits; never dropped.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, counter 0; if_valid_out, dmem_valid_out, ctrl_err_out, bus_req_out, bus_we_out = 0; all data/addr/strb outputs 0; ctrl_stall_out = 0 when no data request. Reset mid-access abandons the bus transaction (bus shares rst_n).
- Data access, zero-wait bus: request at cycle 0, bus_req cycle 1 (gnt cycle 1), rvalid cycle 2, dmem_valid pulse cycle 3, stall high cycles 0-2, low cycle 3.
- Each extra gnt or rvalid wait cycle adds one cycle of latency.
- Misaligned/zero-strobe store: error + valid pulse at cycle 1.
- Timeout: DONE exactly TIMEOUT_CYCLES cycles after entering REQ.
- Back-to-back data accesses: minimum 4 cycles each (DONE gap).

## Test plan
- LW addr 0x100, bus gnt immediate, rvalid next cycle with 0xDEADBEEF -> bus_addr 0x100, we=0; dmem_valid pulse cycle 3 with 0xDEADBEEF; stall high 3 cycles.
- SB addr 0x203 data 0x000000AB -> bus_addr 0x200, wstrb 1000, wdata 0xAB000000; valid pulse after rvalid, no error.
- LB addr 0x102, rdata 0x11223344 -> dmem_rdata_out 0x00001122.
- Simultaneous if_req (0x0) and LW (0x40) in IDLE -> data served first; fetch issued in cycle after data DONE; if_valid pulses once.
- SW addr 0x302 -> no bus_req, ctrl_err_out and dmem_valid_out pulse at cycle 1.
- TIMEOUT_CYCLES=8, gnt given, rvalid never -> err + valid pulse 8 cycles after REQ entry, rdata 0; rst_n asserted mid-RSP -> all outputs 0 immediately.
